// File: rtl/rv_trace_checker.sv
// rtl/rv_trace_checker.sv - lockstep retirement checker: expected-record FIFO plus one-stage field compare
// Records are popped at the retirement edge and judged one cycle later; the first mismatch is latched.
module rv_trace_checker #(
    parameter int DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_enable,
    input  logic                         i_clear,
    input  logic                         i_exp_valid,
    output logic                         o_exp_ready,
    input  logic [31:0]                  i_exp_pc,
    input  logic [31:0]                  i_exp_instr,
    input  logic                         i_exp_reg_write,
    input  logic [31:0]                  i_exp_reg_data,
    input  logic                         i_exp_mem_write,
    input  logic [31:0]                  i_exp_mem_addr,
    input  logic [31:0]                  i_exp_mem_data,
    input  logic [3:0]                   i_exp_mem_sel,
    input  logic                         i_ret_valid,
    input  logic [31:0]                  i_ret_pc,
    input  logic [31:0]                  i_ret_instr,
    input  logic                         i_ret_reg_write,
    input  logic [31:0]                  i_ret_reg_data,
    input  logic                         i_ret_mem_write,
    input  logic [31:0]                  i_ret_mem_addr,
    input  logic [31:0]                  i_ret_mem_data,
    input  logic [3:0]                   i_ret_mem_sel,
    output logic                         o_error,
    output logic [2:0]                   o_err_code,
    output logic [31:0]                  o_err_pc,
    output logic [31:0]                  o_err_instr,
    output logic [31:0]                  o_match_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rw;
        logic [31:0] rd;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [3:0]  sel;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t      state_q;
    rec_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        stg_valid_q;
    logic        stg_uf_q;
    rec_t        stg_exp_q;
    rec_t        stg_act_q;

    rec_t        exp_rec;
    rec_t        act_rec;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        underflow;
    logic        stg_valid_d;
    logic        cmp_fail;
    logic [2:0]  cmp_code;
    logic [31:0] data_mask;

    assign exp_rec = {i_exp_pc, i_exp_instr, i_exp_reg_write, i_exp_reg_data,
                      i_exp_mem_write, i_exp_mem_addr, i_exp_mem_data, i_exp_mem_sel};
    assign act_rec = {i_ret_pc, i_ret_instr, i_ret_reg_write, i_ret_reg_data,
                      i_ret_mem_write, i_ret_mem_addr, i_ret_mem_data, i_ret_mem_sel};

    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_exp_ready  = !full && (state_q != S_FAIL);
    assign o_fifo_level = LW'(wr_ptr_q - rd_ptr_q);
    assign push         = i_exp_valid && o_exp_ready;

    // A failure being reported this cycle blocks the next retirement so the FIFO freezes on the failing record.
    assign pop         = (state_q == S_RUN) && i_ret_valid && !empty && !cmp_fail;
    assign underflow   = (state_q == S_RUN) && i_ret_valid && empty && !cmp_fail;
    assign stg_valid_d = pop || underflow;

    assign data_mask = {{8{stg_exp_q.sel[3]}}, {8{stg_exp_q.sel[2]}},
                        {8{stg_exp_q.sel[1]}}, {8{stg_exp_q.sel[0]}}};

    always_comb begin
        cmp_code = 3'd0;
        if (stg_uf_q)
            cmp_code = 3'd7;
        else if (stg_act_q.pc != stg_exp_q.pc)
            cmp_code = 3'd1;
        else if (stg_act_q.instr != stg_exp_q.instr)
            cmp_code = 3'd2;
        else if (stg_act_q.rw != stg_exp_q.rw)
            cmp_code = 3'd3;
        else if (stg_exp_q.rw && (stg_exp_q.instr[11:7] != 5'd0) && (stg_act_q.rd != stg_exp_q.rd))
            cmp_code = 3'd4;
        else if (stg_act_q.mw != stg_exp_q.mw)
            cmp_code = 3'd5;
        else if (stg_exp_q.mw && ((stg_act_q.ma != stg_exp_q.ma) || (stg_act_q.sel != stg_exp_q.sel) ||
                                  (((stg_act_q.md ^ stg_exp_q.md) & data_mask) != 32'd0)))
            cmp_code = 3'd6;
    end

    assign cmp_fail = stg_valid_q && (cmp_code != 3'd0);

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= exp_rec;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            stg_valid_q <= 1'b0;
            stg_uf_q    <= 1'b0;
            stg_exp_q   <= '0;
            stg_act_q   <= '0;
            o_error     <= 1'b0;
            o_err_code  <= 3'd0;
            o_err_pc    <= 32'd0;
            o_err_instr <= 32'd0;
            o_match_cnt <= 32'd0;
        end else if (i_clear) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            stg_valid_q <= 1'b0;
            stg_uf_q    <= 1'b0;
            o_error     <= 1'b0;
            o_err_code  <= 3'd0;
            o_err_pc    <= 32'd0;
            o_err_instr <= 32'd0;
            o_match_cnt <= 32'd0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            stg_valid_q <= stg_valid_d;
            stg_uf_q    <= underflow;
            if (stg_valid_d) begin
                stg_exp_q <= mem_q[rd_ptr_q[AW-1:0]];
                stg_act_q <= act_rec;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_enable)
                        state_q <= S_RUN;
                end
                S_RUN: begin
                    if (cmp_fail) begin
                        state_q     <= S_FAIL;
                        o_error     <= 1'b1;
                        o_err_code  <= cmp_code;
                        o_err_pc    <= stg_act_q.pc;
                        o_err_instr <= stg_act_q.instr;
                    end else if (stg_valid_q) begin
                        o_match_cnt <= o_match_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_trace_checker.sv
// tb/tb_rv_trace_checker.sv - scoreboard bench for rv_trace_checker with a queue-based reference model
module tb_rv_trace_checker;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rw;
        logic [31:0] rd;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [3:0]  sel;
    } rec_t;

    typedef struct {
        bit          fail;
        int          code;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] match;
    } res_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_exp_valid = 1'b0;
    logic        o_exp_ready;
    logic [31:0] i_exp_pc = '0, i_exp_instr = '0, i_exp_reg_data = '0;
    logic [31:0] i_exp_mem_addr = '0, i_exp_mem_data = '0;
    logic        i_exp_reg_write = 1'b0, i_exp_mem_write = 1'b0;
    logic [3:0]  i_exp_mem_sel = '0;
    logic        i_ret_valid = 1'b0;
    logic [31:0] i_ret_pc = '0, i_ret_instr = '0, i_ret_reg_data = '0;
    logic [31:0] i_ret_mem_addr = '0, i_ret_mem_data = '0;
    logic        i_ret_reg_write = 1'b0, i_ret_mem_write = 1'b0;
    logic [3:0]  i_ret_mem_sel = '0;
    logic        o_error;
    logic [2:0]  o_err_code;
    logic [31:0] o_err_pc, o_err_instr, o_match_cnt;
    logic [3:0]  o_fifo_level;

    rv_trace_checker #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_clear(i_clear),
        .i_exp_valid(i_exp_valid), .o_exp_ready(o_exp_ready),
        .i_exp_pc(i_exp_pc), .i_exp_instr(i_exp_instr), .i_exp_reg_write(i_exp_reg_write),
        .i_exp_reg_data(i_exp_reg_data), .i_exp_mem_write(i_exp_mem_write),
        .i_exp_mem_addr(i_exp_mem_addr), .i_exp_mem_data(i_exp_mem_data), .i_exp_mem_sel(i_exp_mem_sel),
        .i_ret_valid(i_ret_valid), .i_ret_pc(i_ret_pc), .i_ret_instr(i_ret_instr),
        .i_ret_reg_write(i_ret_reg_write), .i_ret_reg_data(i_ret_reg_data),
        .i_ret_mem_write(i_ret_mem_write), .i_ret_mem_addr(i_ret_mem_addr),
        .i_ret_mem_data(i_ret_mem_data), .i_ret_mem_sel(i_ret_mem_sel),
        .o_error(o_error), .o_err_code(o_err_code), .o_err_pc(o_err_pc), .o_err_instr(o_err_instr),
        .o_match_cnt(o_match_cnt), .o_fifo_level(o_fifo_level)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks = 0;
    int   n_fail = 0;
    rec_t mq[$];
    res_t sb[$];
    bit   m_run = 0;
    bit   m_failed = 0;
    int   m_fail_edge = 0;
    int   edge_cnt = 0;
    logic [31:0] m_match = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ref_code(input rec_t e, input rec_t a);
        if (a.pc != e.pc) return 1;
        if (a.instr != e.instr) return 2;
        if (a.rw != e.rw) return 3;
        if (e.rw && e.instr[11:7] != 0 && a.rd != e.rd) return 4;
        if (a.mw != e.mw) return 5;
        if (e.mw) begin
            if (a.ma != e.ma || a.sel != e.sel) return 6;
            for (int b = 0; b < 4; b++)
                if (e.sel[b] && a.md[8*b +: 8] != e.md[8*b +: 8]) return 6;
        end
        return 0;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc = $urandom; r.instr = $urandom; r.rw = 1'($urandom); r.rd = $urandom;
        r.mw = 1'($urandom); r.ma = $urandom; r.md = $urandom; r.sel = 4'($urandom);
        return r;
    endfunction

    function automatic rec_t head_or_rand();
        if (mq.size() > 0) return mq[0];
        return rand_rec();
    endfunction

    function automatic rec_t corrupt(input rec_t r);
        rec_t c = r;
        logic [31:0] bitv = 32'd1 << $urandom_range(0, 31);
        case ($urandom_range(0, 7))
            0: c.pc ^= bitv;
            1: c.instr ^= bitv;
            2: c.rw ^= 1'b1;
            3: c.rd ^= bitv;
            4: c.mw ^= 1'b1;
            5: c.ma ^= bitv;
            6: c.md ^= bitv;
            default: c.sel ^= 4'(bitv);
        endcase
        return c;
    endfunction

    // One clock of stimulus; the model applies the same edge using queue-level rules.
    task automatic step(input bit pv, input rec_t pr, input bit rv, input rec_t ar, input bit en, input bit clr);
        bit m_ready;
        int code;
        res_t r;
        rec_t h;
        i_exp_valid = pv; i_ret_valid = rv; i_enable = en; i_clear = clr;
        {i_exp_pc, i_exp_instr, i_exp_reg_write, i_exp_reg_data,
         i_exp_mem_write, i_exp_mem_addr, i_exp_mem_data, i_exp_mem_sel} = pr;
        {i_ret_pc, i_ret_instr, i_ret_reg_write, i_ret_reg_data,
         i_ret_mem_write, i_ret_mem_addr, i_ret_mem_data, i_ret_mem_sel} = ar;
        m_ready = (mq.size() < DEPTH) && !(m_failed && edge_cnt >= m_fail_edge + 1);
        check("exp_ready", {31'd0, o_exp_ready}, {31'd0, m_ready});
        @(posedge i_clk);
        edge_cnt++;
        if (clr) begin
            mq.delete(); sb.delete();
            m_run = 0; m_failed = 0; m_match = 0;
        end else begin
            if (m_run && !m_failed && rv) begin
                if (mq.size() == 0) code = 7;
                else begin h = mq.pop_front(); code = ref_code(h, ar); end
                if (code != 0) begin
                    m_failed = 1; m_fail_edge = edge_cnt;
                    r = '{1'b1, code, ar.pc, ar.instr, m_match};
                end else begin
                    m_match++;
                    r = '{1'b0, 0, 32'd0, 32'd0, m_match};
                end
                sb.push_back(r);
            end
            if (pv && m_ready) mq.push_back(pr);
            if (!m_run && en) m_run = 1;
        end
        #1;
        check("fifo_level", {28'd0, o_fifo_level}, mq.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) idle(1);
        idle(1);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_error"}, {31'd0, o_error}, 0);
        check({tag, "_code"}, {29'd0, o_err_code}, 0);
        check({tag, "_pc"}, o_err_pc, 0);
        check({tag, "_instr"}, o_err_instr, 0);
        check({tag, "_match"}, o_match_cnt, 0);
        check({tag, "_level"}, {28'd0, o_fifo_level}, 0);
        check({tag, "_ready"}, {31'd0, o_exp_ready}, 1);
    endtask

    // Monitor: every compare result the DUT publishes is matched against the scoreboard head.
    initial begin
        logic [31:0] pm;
        logic        pe;
        res_t        r;
        pm = 0; pe = 0;
        forever begin
            @(negedge i_clk);
            if (i_reset_n && (o_match_cnt == pm + 1 || (o_error && !pe))) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {o_error, o_match_cnt[30:0]}, 32'hFFFF_FFFF);
                end else begin
                    r = sb.pop_front();
                    check("res_error", {31'd0, o_error}, {31'd0, r.fail});
                    check("res_match", o_match_cnt, r.match);
                    if (r.fail) begin
                        check("res_code", {29'd0, o_err_code}, r.code);
                        check("res_pc", o_err_pc, r.pc);
                        check("res_instr", o_err_instr, r.instr);
                    end
                end
            end
            pm = o_match_cnt; pe = o_error;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t e, a;
        #1;
        check_zero("reset");
        repeat (3) @(posedge i_clk);
        #2 i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Four matching addi r1,r0,5 retirements.
        step(0, '0, 0, '0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            e = '{32'(i * 4), 32'h0050_0093, 1'b1, 32'd5, 1'b0, 32'd0, 32'd0, 4'd0};
            step(1, e, 0, '0, 0, 0);
        end
        for (int i = 0; i < 4; i++) step(0, '0, 1, head_or_rand(), 0, 0);
        drain();
        check("t1_match", o_match_cnt, 4);
        check("t1_error", {31'd0, o_error}, 0);
        check("t1_level", {28'd0, o_fifo_level}, 0);

        // Register data mismatch, then a retirement that must be ignored.
        e = '{32'h10, 32'h0050_0093, 1'b1, 32'd5, 1'b0, 32'd0, 32'd0, 4'd0};
        step(1, e, 0, '0, 0, 0);
        a = e; a.rd = 32'd6;
        step(0, '0, 1, a, 0, 0);
        step(0, '0, 1, rand_rec(), 0, 0);
        drain();
        check("t2_code", {29'd0, o_err_code}, 4);
        check("t2_pc", o_err_pc, 32'h10);
        check("t2_match", o_match_cnt, 4);
        step(0, '0, 0, '0, 0, 1);
        idle(1);
        check_zero("t2_clear");

        // Store data compared only on selected bytes.
        step(0, '0, 0, '0, 1, 0);
        e = '{32'h20, 32'h0011_2023, 1'b0, 32'd0, 1'b1, 32'h100, 32'h1122_3344, 4'b0010};
        step(1, e, 0, '0, 0, 0);
        a = e; a.md = 32'h1122_33FF;
        step(1, e, 1, a, 0, 0);
        a = e; a.md = 32'h1122_FF44;
        step(0, '0, 1, a, 0, 0);
        drain();
        check("t3_match", o_match_cnt, 1);
        check("t3_code", {29'd0, o_err_code}, 6);
        step(0, '0, 0, '0, 0, 1);

        // Underflow on an empty FIFO, then clear.
        step(0, '0, 0, '0, 1, 0);
        e = rand_rec();
        step(1, e, 1, rand_rec(), 0, 0);
        drain();
        check("t4_code", {29'd0, o_err_code}, 7);
        step(0, '0, 0, '0, 0, 1);
        idle(1);
        check_zero("t4_clear");

        // Fill in IDLE, then push+retire every cycle across pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1, rand_rec(), 0, '0, 0, 0);
        check("t5_full_ready", {31'd0, o_exp_ready}, 0);
        check("t5_full_level", {28'd0, o_fifo_level}, DEPTH);
        step(0, '0, 0, '0, 1, 0);
        for (int i = 0; i < 40; i++) step(1, rand_rec(), 1, head_or_rand(), 0, 0);
        drain();
        check("t5_match", o_match_cnt, 40);
        check("t5_error", {31'd0, o_error}, 0);
        check("t5_level", {28'd0, o_fifo_level}, DEPTH - 1);

        // rd = r0 ignores the data value.
        step(0, '0, 0, '0, 0, 1);
        step(0, '0, 0, '0, 1, 0);
        e = '{32'h40, 32'h0050_0013, 1'b1, 32'd5, 1'b0, 32'd0, 32'd0, 4'd0};
        step(1, e, 0, '0, 0, 0);
        a = e; a.rd = 32'd9;
        step(0, '0, 1, a, 0, 0);
        drain();
        check("t6_match", o_match_cnt, 1);
        check("t6_error", {31'd0, o_error}, 0);

        // Randomized traffic with occasional corruption; clear after each failure.
        for (int it = 0; it < 400; it++) begin
            bit pv, rv;
            pv = ($urandom_range(0, 2) != 0);
            rv = 1'($urandom_range(0, 1));
            a = head_or_rand();
            if ($urandom_range(0, 9) == 0) a = corrupt(a);
            step(pv, rand_rec(), rv, a, 1, 0);
            if (m_failed && edge_cnt >= m_fail_edge + 3) begin
                drain();
                step(0, '0, 0, '0, 0, 1);
            end
        end

        // Asynchronous reset mid-stream.
        step(0, '0, 0, '0, 0, 1);
        step(0, '0, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, rand_rec(), 0, '0, 0, 0);
        step(1, rand_rec(), 1, head_or_rand(), 0, 0);
        step(1, rand_rec(), 1, head_or_rand(), 0, 0);
        #2 i_reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        mq.delete(); sb.delete();
        m_run = 0; m_failed = 0; m_match = 0;
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        idle(2);
        check_zero("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
